cache_nway: RTL and testbench
=============================

Name: cache_nway

Overview:
- Parametrised N-way set-associative, write-through, write-allocate cache; next generation of the 2-way data cache.
- Sits between a requesting core and the word-addressed RAM model.
- Replaces input-change detection with an explicit valid/ready request handshake and a req/ack memory port.
- Adds a per-set round-robin victim pointer and read hit/miss counters.

Parameters:
- WAYS, 2, associativity; power of two, 1..8.
- SET_BITS, 5, index width; SETS = 2**SET_BITS.
- ADDR_W, 32, word-address width.
- DATA_W, 32, data word width.
- CNT_W, 32, hit/miss counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  cache can accept a request this cycle.
- req_wr  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  word address.
- req_wdata  in  DATA_W  write data.
- resp_valid  out  1  one-cycle completion pulse.
- resp_data  out  DATA_W  read data; valid with resp_valid on reads.
- resp_miss  out  1  1 if the completed read missed; 0 for writes.
- mem_req  out  1  memory request, held until mem_ack.
- mem_wr  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_ack  in  1  memory done; one-cycle pulse.
- mem_rdata  in  DATA_W  memory read data; valid with mem_ack.
- hit_cnt  out  CNT_W  read hits since reset.
- miss_cnt  out  CNT_W  read misses since reset.

Behaviour:
- Address split: index = req_addr[SET_BITS-1:0]; tag = req_addr[ADDR_W-1:SET_BITS]. One word per line.
- Line state: valid bit, tag, data. Each set has a log2(WAYS)-bit victim pointer.
- Reset (async): FSM goes to IDLE; all valid bits, victim pointers and counters clear to 0.
- Reset output values: req_ready=1, resp_valid=0, resp_data=0, resp_miss=0, mem_req=0, mem_wr=0, mem_addr=0, mem_wdata=0.
- Reset during any state: mem_req drops immediately and the in-flight transaction is discarded without a response.
- FSM states: IDLE, RD_MISS, WR_MEM.
- IDLE:
  - req_ready=1. A request is accepted on a clock edge where req_valid && req_ready; address and data are latched.
  - Read hit (valid && tag match in any way): resp_valid=1 with the hit data and resp_miss=0 in the next cycle; hit_cnt increments; FSM stays in IDLE.
  - Read miss: FSM goes to RD_MISS; miss_cnt increments; next cycle mem_req=1, mem_wr=0, mem_addr = latched address.
  - Write (hit or miss): FSM goes to WR_MEM; next cycle mem_req=1, mem_wr=1, mem_addr and mem_wdata = latched values.
  - Write hit: the line data is updated in place at acceptance.
  - Write miss: the word is allocated into the victim way at acceptance.
- RD_MISS:
  - req_ready=0; mem_req, mem_wr and mem_addr stay stable until mem_ack.
  - On mem_ack: mem_rdata is filled into the victim way (valid=1, tag set); mem_req drops; FSM returns to IDLE.
  - Cycle after mem_ack: resp_valid=1, resp_data = mem_rdata, resp_miss=1.
- WR_MEM:
  - req_ready=0; memory outputs stay stable until mem_ack.
  - On mem_ack: mem_req drops; FSM returns to IDLE.
  - Cycle after mem_ack: resp_valid=1, resp_miss=0, resp_data unchanged.
- resp_valid is low in all cycles other than those stated. Requests held with req_ready=0 are not consumed.
- Back-to-back: a new request may be accepted in the same cycle resp_valid is high.
- Victim selection: lowest-index invalid way; if every way is valid, the way at the set's victim pointer, which then advances by 1 modulo WAYS. Hits never move the pointer.
- At most one way may match; a fill never creates a duplicate tag, because fills occur only after a miss.
- mem_ack received while mem_req=0 is ignored.
- Counters wrap modulo 2**CNT_W; write operations are not counted.

Test Plan:
- After reset, read 0x40 -> mem_req with mem_addr=0x40; ack after 3 cycles with 0xDEADBEEF -> resp_valid, resp_data=0xDEADBEEF, resp_miss=1, miss_cnt=1. Re-read 0x40 -> resp_valid 1 cycle after accept, resp_miss=0, no mem_req, hit_cnt=1.
- WAYS=2: read 0x00, 0x20, 0x40 (all set 0); 0x40 evicts 0x00 (pointer=0 -> 1). Re-read 0x20 and 0x40 -> hits; re-read 0x00 -> miss, evicts 0x20.
- Write 0x11223344 to 0x05 -> mem_req=1, mem_wr=1, mem_addr=0x05, mem_wdata=0x11223344; ack -> resp_valid, resp_miss=0. Read 0x05 -> hit, 0x11223344, no mem_req.
- Write 0xCAFEF00D to resident 0x40 -> in-place update, pointer unchanged; read 0x40 -> hit, 0xCAFEF00D; hit_cnt +1, miss_cnt unchanged.
- Assert rst 2 cycles into a read-miss wait -> mem_req=0 immediately and no resp_valid. After release, read 0x40 -> miss; hit_cnt=0, miss_cnt=1.
- WAYS=4, SET_BITS=2: five reads 0x0, 0x4, 0x8, 0xC, 0x10 -> fifth evicts 0x0. Re-reads of 0x4..0x10 hit; 0x0 misses.

Source files
------------

// File: rtl/cache_nway.sv
// N-way set-associative, write-through / write-allocate cache: one word per line,
// valid/ready request port, req/ack memory port, per-set round-robin victim pointer.
module cache_nway #(
  parameter int WAYS     = 2,
  parameter int SET_BITS = 5,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int CNT_W    = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_wr,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [DATA_W-1:0] i_req_wdata,
  output logic              o_resp_valid,
  output logic [DATA_W-1:0] o_resp_data,
  output logic              o_resp_miss,
  output logic              o_mem_req,
  output logic              o_mem_wr,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic              i_mem_ack,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic [CNT_W-1:0]  o_hit_cnt,
  output logic [CNT_W-1:0]  o_miss_cnt
);

  localparam int SETS  = 2 ** SET_BITS;
  localparam int TAG_W = ADDR_W - SET_BITS;
  localparam int WB    = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RD_MISS = 2'd1,
    S_WR_MEM  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [WAYS-1:0]   r_valid [SETS];
  logic [WB-1:0]     r_vptr  [SETS];
  logic [TAG_W-1:0]  r_tag   [SETS][WAYS];
  logic [DATA_W-1:0] r_data  [SETS][WAYS];

  logic              r_req_ready;
  logic              r_resp_valid;
  logic [DATA_W-1:0] r_resp_data;
  logic              r_resp_miss;
  logic              r_mem_req;
  logic              r_mem_wr;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [CNT_W-1:0]  r_hit_cnt;
  logic [CNT_W-1:0]  r_miss_cnt;

  logic [SET_BITS-1:0] w_idx;
  logic [TAG_W-1:0]    w_tag;
  logic [WAYS-1:0]     w_hit_vec;
  logic                w_hit;
  logic [WB-1:0]       w_hit_way;
  logic [DATA_W-1:0]   w_hit_data;
  logic [WB-1:0]       w_free_way;
  logic                w_all_valid;
  logic [WB-1:0]       w_vict;
  logic [WB-1:0]       w_vptr_nxt;
  logic                w_accept;
  logic                w_rd_hit;
  logic                w_rd_miss;
  logic                w_wr_acc;
  logic                w_fill;
  logic                w_wr_done;
  logic                w_upd;
  logic                w_alloc;
  logic [WB-1:0]       w_upd_way;
  logic [DATA_W-1:0]   w_upd_data;

  // While busy, the latched request address lives in r_mem_addr, so it selects the set.
  assign w_idx = (r_state == S_IDLE) ? i_req_addr[SET_BITS-1:0] : r_mem_addr[SET_BITS-1:0];
  assign w_tag = (r_state == S_IDLE) ? i_req_addr[ADDR_W-1:SET_BITS] : r_mem_addr[ADDR_W-1:SET_BITS];

  // Tag lookup and lowest-index free way search for the selected set.
  always_comb begin
    w_hit_vec  = '0;
    w_hit_way  = '0;
    w_hit_data = '0;
    w_free_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      w_hit_vec[w] = r_valid[w_idx][w] && (r_tag[w_idx][w] == w_tag);
      w_hit_way    = w_hit_way | (w_hit_vec[w] ? WB'(w) : {WB{1'b0}});
      w_hit_data   = w_hit_data | ({DATA_W{w_hit_vec[w]}} & r_data[w_idx][w]);
    end
    for (int w = WAYS - 1; w >= 0; w--) begin
      w_free_way = r_valid[w_idx][w] ? w_free_way : WB'(w);
    end
  end

  assign w_hit       = |w_hit_vec;
  assign w_all_valid = &r_valid[w_idx];
  assign w_vict      = w_all_valid ? r_vptr[w_idx] : w_free_way;
  assign w_vptr_nxt  = (r_vptr[w_idx] == WB'(WAYS - 1)) ? {WB{1'b0}} : r_vptr[w_idx] + WB'(1);

  assign w_accept  = i_req_valid && (r_state == S_IDLE);
  assign w_rd_hit  = w_accept && !i_req_wr && w_hit;
  assign w_rd_miss = w_accept && !i_req_wr && !w_hit;
  assign w_wr_acc  = w_accept && i_req_wr;
  assign w_fill    = (r_state == S_RD_MISS) && i_mem_ack && r_mem_req;
  assign w_wr_done = (r_state == S_WR_MEM) && i_mem_ack && r_mem_req;

  // Writes land at acceptance; read misses are filled only when memory answers.
  assign w_upd      = w_wr_acc || w_fill;
  assign w_alloc    = w_fill || (w_wr_acc && !w_hit);
  assign w_upd_way  = (w_wr_acc && w_hit) ? w_hit_way : w_vict;
  assign w_upd_data = w_wr_acc ? i_req_wdata : i_mem_rdata;

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_req_valid) begin
          if (i_req_wr) begin
            w_state_nxt = S_WR_MEM;
          end else if (!w_hit) begin
            w_state_nxt = S_RD_MISS;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_RD_MISS: begin
        if (w_fill) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_RD_MISS;
        end
      end
      S_WR_MEM: begin
        if (w_wr_done) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_WR_MEM;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register and registered ready.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_req_ready <= 1'b1;
    end else begin
      r_state     <= w_state_nxt;
      r_req_ready <= (w_state_nxt == S_IDLE);
    end
  end

  // Valid bits and victim pointers; only allocations into a full set move the pointer.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int s = 0; s < SETS; s++) begin
        r_valid[s] <= '0;
        r_vptr[s]  <= '0;
      end
    end else if (w_upd) begin
      r_valid[w_idx][w_upd_way] <= 1'b1;
      if (w_alloc && w_all_valid) begin
        r_vptr[w_idx] <= w_vptr_nxt;
      end
    end
  end

  // Tag and data storage need no reset: nothing is read while the valid bit is clear.
  always_ff @(posedge i_clk) begin
    if (w_upd) begin
      r_tag[w_idx][w_upd_way]  <= w_tag;
      r_data[w_idx][w_upd_way] <= w_upd_data;
    end
  end

  // Response, memory port and counters.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_resp_valid <= 1'b0;
      r_resp_data  <= '0;
      r_resp_miss  <= 1'b0;
      r_mem_req    <= 1'b0;
      r_mem_wr     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_hit_cnt    <= '0;
      r_miss_cnt   <= '0;
    end else begin
      r_resp_valid <= 1'b0;
      if (w_rd_hit) begin
        r_resp_valid <= 1'b1;
        r_resp_data  <= w_hit_data;
        r_resp_miss  <= 1'b0;
        r_hit_cnt    <= r_hit_cnt + CNT_W'(1);
      end else if (w_rd_miss) begin
        r_miss_cnt <= r_miss_cnt + CNT_W'(1);
        r_mem_req  <= 1'b1;
        r_mem_wr   <= 1'b0;
        r_mem_addr <= i_req_addr;
      end else if (w_wr_acc) begin
        r_mem_req   <= 1'b1;
        r_mem_wr    <= 1'b1;
        r_mem_addr  <= i_req_addr;
        r_mem_wdata <= i_req_wdata;
      end else if (w_fill) begin
        r_mem_req    <= 1'b0;
        r_resp_valid <= 1'b1;
        r_resp_data  <= i_mem_rdata;
        r_resp_miss  <= 1'b1;
      end else if (w_wr_done) begin
        r_mem_req    <= 1'b0;
        r_resp_valid <= 1'b1;
        r_resp_miss  <= 1'b0;
      end
    end
  end

  assign o_req_ready  = r_req_ready;
  assign o_resp_valid = r_resp_valid;
  assign o_resp_data  = r_resp_data;
  assign o_resp_miss  = r_resp_miss;
  assign o_mem_req    = r_mem_req;
  assign o_mem_wr     = r_mem_wr;
  assign o_mem_addr   = r_mem_addr;
  assign o_mem_wdata  = r_mem_wdata;
  assign o_hit_cnt    = r_hit_cnt;
  assign o_miss_cnt   = r_miss_cnt;

endmodule

// File: tb/tb_cache_nway.sv
// Bench for cache_nway: a 2-way/32-set instance (unit 0) and a 4-way/4-set instance
// (unit 1), directed vector table plus random traffic against a line-level model.
module tb_cache_nway;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0]  req_valid, req_ready, req_wr, resp_valid, resp_miss, mem_req, mem_wr, mem_ack;
  logic [31:0] req_addr [2];
  logic [31:0] req_wdata [2];
  logic [31:0] resp_data [2];
  logic [31:0] mem_addr [2];
  logic [31:0] mem_wdata [2];
  logic [31:0] mem_rdata [2];
  logic [31:0] hit_cnt [2];
  logic [31:0] miss_cnt [2];

  cache_nway #(.WAYS(2), .SET_BITS(5)) u_dut0 (
    .i_clk(clk), .i_rst(rst),
    .i_req_valid(req_valid[0]), .o_req_ready(req_ready[0]), .i_req_wr(req_wr[0]),
    .i_req_addr(req_addr[0]), .i_req_wdata(req_wdata[0]),
    .o_resp_valid(resp_valid[0]), .o_resp_data(resp_data[0]), .o_resp_miss(resp_miss[0]),
    .o_mem_req(mem_req[0]), .o_mem_wr(mem_wr[0]), .o_mem_addr(mem_addr[0]),
    .o_mem_wdata(mem_wdata[0]), .i_mem_ack(mem_ack[0]), .i_mem_rdata(mem_rdata[0]),
    .o_hit_cnt(hit_cnt[0]), .o_miss_cnt(miss_cnt[0])
  );

  cache_nway #(.WAYS(4), .SET_BITS(2)) u_dut1 (
    .i_clk(clk), .i_rst(rst),
    .i_req_valid(req_valid[1]), .o_req_ready(req_ready[1]), .i_req_wr(req_wr[1]),
    .i_req_addr(req_addr[1]), .i_req_wdata(req_wdata[1]),
    .o_resp_valid(resp_valid[1]), .o_resp_data(resp_data[1]), .o_resp_miss(resp_miss[1]),
    .o_mem_req(mem_req[1]), .o_mem_wr(mem_wr[1]), .o_mem_addr(mem_addr[1]),
    .o_mem_wdata(mem_wdata[1]), .i_mem_ack(mem_ack[1]), .i_mem_rdata(mem_rdata[1]),
    .o_hit_cnt(hit_cnt[1]), .o_miss_cnt(miss_cnt[1])
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  // Reference model: each set is a list of up to WAYS resident words plus a rotating slot.
  bit          mv [2][32][4];
  logic [31:0] mt [2][32][4];
  logic [31:0] md [2][32][4];
  int          mp [2][32];
  logic [31:0] eh [2];
  logic [31:0] em [2];
  logic [31:0] last_resp [2];
  logic [31:0] ram [logic [32:0]];

  function automatic int ways_of(input int u);
    return (u == 1) ? 4 : 2;
  endfunction

  function automatic int sb_of(input int u);
    return (u == 1) ? 2 : 5;
  endfunction

  function automatic logic [32:0] ram_key(input int u, input logic [31:0] a);
    logic [32:0] k;
    k = {(u == 1) ? 1'b1 : 1'b0, a};
    return k;
  endfunction

  function automatic logic [31:0] ram_rd(input int u, input logic [31:0] a);
    if (ram.exists(ram_key(u, a))) return ram[ram_key(u, a)];
    return 32'h5A00_0000 | a;
  endfunction

  function automatic void model_reset();
    for (int u = 0; u < 2; u++) begin
      for (int s = 0; s < 32; s++) begin
        mp[u][s] = 0;
        for (int w = 0; w < 4; w++) mv[u][s][w] = 1'b0;
      end
      eh[u] = 32'd0;
      em[u] = 32'd0;
      last_resp[u] = 32'd0;
    end
  endfunction

  function automatic void model_access(input int u, input bit wr, input logic [31:0] a,
                                       input logic [31:0] wd, output bit hit, output logic [31:0] rd);
    int nw, set, hw, vw;
    logic [31:0] tg;
    nw  = ways_of(u);
    set = int'(a % (32'd1 << sb_of(u)));
    tg  = a >> sb_of(u);
    hw  = -1;
    for (int w = 0; w < nw; w++) if (mv[u][set][w] && mt[u][set][w] == tg) hw = w;
    hit = (hw >= 0);
    if (wr) ram[ram_key(u, a)] = wd;
    if (hit && !wr) begin
      rd = md[u][set][hw];
      eh[u]++;
      last_resp[u] = rd;
    end else if (hit && wr) begin
      md[u][set][hw] = wd;
      rd = last_resp[u];
    end else begin
      vw = -1;
      for (int w = 0; w < nw; w++) if (!mv[u][set][w] && vw < 0) vw = w;
      if (vw < 0) begin
        vw = mp[u][set];
        mp[u][set] = (mp[u][set] + 1) % nw;
      end
      mv[u][set][vw] = 1'b1;
      mt[u][set][vw] = tg;
      if (wr) begin
        md[u][set][vw] = wd;
        rd = last_resp[u];
      end else begin
        md[u][set][vw] = ram_rd(u, a);
        rd = md[u][set][vw];
        em[u]++;
        last_resp[u] = rd;
      end
    end
  endfunction

  // One complete transaction; entered and left just after a falling edge.
  task automatic do_req(input int u, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                        input int lat, input bit exp_hit, input logic [31:0] exp_data,
                        input logic [31:0] exp_h, input logic [31:0] exp_m, input string nm);
    logic [31:0] rdv;
    rdv = ram_rd(u, a);
    chk({nm, " ready"}, 32'(req_ready[u]), 32'd1);
    req_valid[u] = 1'b1;
    req_wr[u]    = wr;
    req_addr[u]  = a;
    req_wdata[u] = wd;
    @(posedge clk);
    @(negedge clk);
    req_valid[u] = 1'b0;
    if (!wr && exp_hit) begin
      chk({nm, " hit resp_valid/miss/mem_req"}, 32'({resp_valid[u], resp_miss[u], mem_req[u]}), 32'h4);
      chk({nm, " hit data"}, resp_data[u], exp_data);
    end else begin
      chk({nm, " mem_req/mem_wr/resp_valid/ready"},
          32'({mem_req[u], mem_wr[u], resp_valid[u], req_ready[u]}), 32'({1'b1, wr, 2'b00}));
      chk({nm, " mem_addr"}, mem_addr[u], a);
      if (wr) chk({nm, " mem_wdata"}, mem_wdata[u], wd);
      for (int i = 0; i < lat; i++) begin
        @(negedge clk);
        chk({nm, " wait mem_req/resp_valid/ready"},
            32'({mem_req[u], resp_valid[u], req_ready[u]}), 32'h4);
      end
      mem_ack[u]   = 1'b1;
      mem_rdata[u] = wr ? $urandom : rdv;
      @(negedge clk);
      mem_ack[u]   = 1'b0;
      mem_rdata[u] = $urandom;
      chk({nm, " done resp_valid/miss/mem_req/ready"},
          32'({resp_valid[u], resp_miss[u], mem_req[u], req_ready[u]}), 32'({1'b1, !wr, 2'b01}));
      chk({nm, " done data"}, resp_data[u], exp_data);
    end
    chk({nm, " hit_cnt"}, hit_cnt[u], exp_h);
    chk({nm, " miss_cnt"}, miss_cnt[u], exp_m);
  endtask

  task automatic chk_reset_outputs(input string nm);
    for (int u = 0; u < 2; u++) begin
      chk($sformatf("%s u%0d ctl", nm, u),
          32'({req_ready[u], resp_valid[u], resp_miss[u], mem_req[u], mem_wr[u]}), 32'h10);
      chk($sformatf("%s u%0d resp_data", nm, u), resp_data[u], 32'd0);
      chk($sformatf("%s u%0d mem_addr", nm, u), mem_addr[u], 32'd0);
      chk($sformatf("%s u%0d mem_wdata", nm, u), mem_wdata[u], 32'd0);
      chk($sformatf("%s u%0d counters", nm, u), hit_cnt[u] | miss_cnt[u], 32'd0);
    end
  endtask

  // kind: 0 = request, 1 = reset during a read-miss wait, 2 = stray mem_ack while idle
  typedef struct {
    int          kind;
    int          u;
    bit          wr;
    logic [31:0] a;
    logic [31:0] wd;
    int          lat;
    bit          hit;
    logic [31:0] d;
    logic [31:0] h;
    logic [31:0] m;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input int kind, input int u, input bit wr, input logic [31:0] a,
                              input logic [31:0] wd, input int lat, input bit hit,
                              input logic [31:0] d, input logic [31:0] h, input logic [31:0] m);
    vec_t v;
    v = '{kind, u, wr, a, wd, lat, hit, d, h, m};
    tbl.push_back(v);
  endfunction

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          mh;
    logic [31:0] mdat;
    rst = 1'b1;
    req_valid = '0;
    req_wr    = '0;
    mem_ack   = '0;
    for (int u = 0; u < 2; u++) begin
      req_addr[u] = 32'd0; req_wdata[u] = 32'd0; mem_rdata[u] = 32'd0;
    end
    model_reset();
    ram[ram_key(0, 32'h40)] = 32'hDEAD_BEEF;

    //  kind u  wr  addr    wdata          lat hit data           hits   misses
    add(0, 0, 0, 32'h40, 32'h0,         3, 0, 32'hDEAD_BEEF, 32'd0, 32'd1);
    add(0, 0, 0, 32'h40, 32'h0,         0, 1, 32'hDEAD_BEEF, 32'd1, 32'd1);
    add(0, 0, 1, 32'h05, 32'h1122_3344, 2, 0, 32'hDEAD_BEEF, 32'd1, 32'd1);
    add(0, 0, 0, 32'h05, 32'h0,         0, 1, 32'h1122_3344, 32'd2, 32'd1);
    add(0, 0, 1, 32'h40, 32'hCAFE_F00D, 1, 0, 32'h1122_3344, 32'd2, 32'd1);
    add(0, 0, 0, 32'h40, 32'h0,         0, 1, 32'hCAFE_F00D, 32'd3, 32'd1);
    add(1, 0, 0, 32'h60, 32'h0,         0, 0, 32'h0,         32'd0, 32'd0);
    add(0, 0, 0, 32'h40, 32'h0,         2, 0, 32'hCAFE_F00D, 32'd0, 32'd1);
    add(0, 0, 0, 32'h01, 32'h0,         1, 0, 32'h5A00_0001, 32'd0, 32'd2);
    add(0, 0, 0, 32'h21, 32'h0,         0, 0, 32'h5A00_0021, 32'd0, 32'd3);
    add(0, 0, 0, 32'h41, 32'h0,         4, 0, 32'h5A00_0041, 32'd0, 32'd4);
    add(0, 0, 0, 32'h21, 32'h0,         0, 1, 32'h5A00_0021, 32'd1, 32'd4);
    add(0, 0, 0, 32'h41, 32'h0,         0, 1, 32'h5A00_0041, 32'd2, 32'd4);
    add(0, 0, 0, 32'h01, 32'h0,         1, 0, 32'h5A00_0001, 32'd2, 32'd5);
    add(0, 0, 0, 32'h21, 32'h0,         1, 0, 32'h5A00_0021, 32'd2, 32'd6);
    add(0, 0, 0, 32'h01, 32'h0,         0, 1, 32'h5A00_0001, 32'd3, 32'd6);
    add(2, 0, 0, 32'h0,  32'h0,         0, 0, 32'h5A00_0001, 32'd3, 32'd6);
    add(0, 1, 0, 32'h00, 32'h0,         1, 0, 32'h5A00_0000, 32'd0, 32'd1);
    add(0, 1, 0, 32'h04, 32'h0,         0, 0, 32'h5A00_0004, 32'd0, 32'd2);
    add(0, 1, 0, 32'h08, 32'h0,         2, 0, 32'h5A00_0008, 32'd0, 32'd3);
    add(0, 1, 0, 32'h0C, 32'h0,         1, 0, 32'h5A00_000C, 32'd0, 32'd4);
    add(0, 1, 0, 32'h10, 32'h0,         3, 0, 32'h5A00_0010, 32'd0, 32'd5);
    add(0, 1, 0, 32'h04, 32'h0,         0, 1, 32'h5A00_0004, 32'd1, 32'd5);
    add(0, 1, 0, 32'h08, 32'h0,         0, 1, 32'h5A00_0008, 32'd2, 32'd5);
    add(0, 1, 0, 32'h0C, 32'h0,         0, 1, 32'h5A00_000C, 32'd3, 32'd5);
    add(0, 1, 0, 32'h10, 32'h0,         0, 1, 32'h5A00_0010, 32'd4, 32'd5);
    add(0, 1, 0, 32'h00, 32'h0,         2, 0, 32'h5A00_0000, 32'd4, 32'd6);
    add(0, 1, 0, 32'h04, 32'h0,         1, 0, 32'h5A00_0004, 32'd4, 32'd7);

    repeat (2) @(negedge clk);
    chk_reset_outputs("reset held");
    rst = 1'b0;
    @(negedge clk);
    chk_reset_outputs("after reset");

    foreach (tbl[i]) begin
      vec_t t;
      string nm;
      t  = tbl[i];
      nm = $sformatf("vec%0d", i);
      if (t.kind == 0) begin
        model_access(t.u, t.wr, t.a, t.wd, mh, mdat);
        do_req(t.u, t.wr, t.a, t.wd, t.lat, t.hit, t.d, t.h, t.m, nm);
      end else if (t.kind == 1) begin
        chk({nm, " ready"}, 32'(req_ready[t.u]), 32'd1);
        req_valid[t.u] = 1'b1; req_wr[t.u] = 1'b0; req_addr[t.u] = t.a;
        @(posedge clk);
        @(negedge clk);
        req_valid[t.u] = 1'b0;
        chk({nm, " mem_req before reset"}, 32'(mem_req[t.u]), 32'd1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        chk({nm, " mem_req drops at reset"}, 32'(mem_req[t.u]), 32'd0);
        chk_reset_outputs({nm, " in reset"});
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        chk_reset_outputs({nm, " after reset"});
        @(negedge clk);
        chk({nm, " no late resp"}, 32'({resp_valid[t.u], mem_req[t.u]}), 32'd0);
      end else begin
        mem_ack[t.u] = 1'b1;
        mem_rdata[t.u] = 32'h0BAD_0BAD;
        @(negedge clk);
        mem_ack[t.u] = 1'b0;
        chk({nm, " stray ack resp_valid/mem_req/ready"},
            32'({resp_valid[t.u], mem_req[t.u], req_ready[t.u]}), 32'h1);
        chk({nm, " stray ack resp_data"}, resp_data[t.u], t.d);
        chk({nm, " stray ack hit_cnt"}, hit_cnt[t.u], t.h);
        chk({nm, " stray ack miss_cnt"}, miss_cnt[t.u], t.m);
      end
    end

    for (int n = 0; n < 400; n++) begin
      int          u, lat;
      bit          wr;
      logic [31:0] a, wd;
      u   = $urandom_range(0, 1);
      wr  = ($urandom_range(0, 3) == 0);
      a   = (u == 1) ? 32'($urandom_range(0, 23))
                     : ((32'($urandom_range(0, 3)) << 5) | 32'($urandom_range(0, 1)));
      wd  = $urandom;
      lat = $urandom_range(0, 3);
      model_access(u, wr, a, wd, mh, mdat);
      do_req(u, wr, a, wd, lat, mh, mdat, eh[u], em[u], $sformatf("rnd%0d u%0d", n, u));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
